// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared codes, FSM states and default widths for the memory arbiter
package mem_arb_pkg;

  localparam int DEF_ADDR_W       = 16;
  localparam int DEF_DATA_W       = 8;
  localparam int DEF_MON_WAIT_MAX = 4;

  typedef enum logic [1:0] {
    CS_IDLE  = 2'b00,
    CS_IN    = 2'b01,
    CS_CHECK = 2'b10,
    CS_RUN   = 2'b11
  } cpustate_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_LD   = 2'b10,
    OWN_MON  = 2'b11
  } owner_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ACCESS  = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_RESP    = 2'b11
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester handshakes and memory port of the shared-memory arbiter
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic [1:0]        cpustate;

  logic              cpu_req,   ld_req,   mon_req;
  logic              cpu_we,    ld_we,    mon_we;
  logic [ADDR_W-1:0] cpu_addr,  ld_addr,  mon_addr;
  logic [DATA_W-1:0] cpu_wdata, ld_wdata, mon_wdata;
  logic              cpu_ack,   ld_ack,   mon_ack;

  logic [DATA_W-1:0] rdata;
  logic [1:0]        owner;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re, mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  cpustate,
    input  cpu_req, ld_req, mon_req,
    input  cpu_we, ld_we, mon_we,
    input  cpu_addr, ld_addr, mon_addr,
    input  cpu_wdata, ld_wdata, mon_wdata,
    output cpu_ack, ld_ack, mon_ack,
    output rdata, owner,
    output mem_addr, mem_wdata, mem_re, mem_we,
    input  mem_rdata
  );

  // Requesters plus memory side
  modport master (
    output cpustate,
    output cpu_req, ld_req, mon_req,
    output cpu_we, ld_we, mon_we,
    output cpu_addr, ld_addr, mon_addr,
    output cpu_wdata, ld_wdata, mon_wdata,
    input  cpu_ack, ld_ack, mon_ack,
    input  rdata, owner,
    input  mem_addr, mem_wdata, mem_re, mem_we,
    output mem_rdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner selection gated by cpustate
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_cpustate,
  input  logic       i_cpu_req,
  input  logic       i_ld_req,
  input  logic       i_mon_req,
  input  logic       i_force_mon,
  output owner_t     o_owner
);

  always_comb begin
    o_owner = OWN_NONE;
    case (cpustate_t'(i_cpustate))
      CS_IN:    if (i_ld_req)  o_owner = OWN_LD;
      CS_CHECK: if (i_mon_req) o_owner = OWN_MON;
      CS_RUN: begin
        // cpu normally wins; a starved monitor is forced through once
        if (i_mon_req && (i_force_mon || !i_cpu_req)) o_owner = OWN_MON;
        else if (i_cpu_req)                           o_owner = OWN_CPU;
      end
      default: o_owner = OWN_NONE;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - four-state shared-memory arbiter for cpu, loader and monitor
// Optional monitor anti-starvation counter enabled by MEM_ARB_STARVE_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int MON_WAIT_MAX = DEF_MON_WAIT_MAX
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  if (MON_WAIT_MAX < 1 || MON_WAIT_MAX > 7) begin : g_bad_mon_wait_max
    $error("MON_WAIT_MAX must fit the 3-bit starvation counter (1..7)");
  end

  arb_state_t        r_state;
  owner_t            r_owner;
  logic              r_we;
  logic [2:0]        r_ack;
  logic [DATA_W-1:0] r_rdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_re;
  logic              r_mem_we;

  owner_t            w_pick;
  logic              w_force_mon;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  mem_arb_pick u_pick (
    .i_cpustate  (bus.cpustate),
    .i_cpu_req   (bus.cpu_req),
    .i_ld_req    (bus.ld_req),
    .i_mon_req   (bus.mon_req),
    .i_force_mon (w_force_mon),
    .o_owner     (w_pick)
  );

  always_comb begin
    w_sel_we    = bus.cpu_we;
    w_sel_addr  = bus.cpu_addr;
    w_sel_wdata = bus.cpu_wdata;
    case (w_pick)
      OWN_LD: begin
        w_sel_we    = bus.ld_we;
        w_sel_addr  = bus.ld_addr;
        w_sel_wdata = bus.ld_wdata;
      end
      OWN_MON: begin
        w_sel_we    = bus.mon_we;
        w_sel_addr  = bus.mon_addr;
        w_sel_wdata = bus.mon_wdata;
      end
      default: ;
    endcase
  end

`ifdef MEM_ARB_STARVE_EN
  logic [2:0] r_starve_cnt;

  assign w_force_mon = (r_starve_cnt >= 3'(MON_WAIT_MAX));

  // Counts picks that passed over a waiting monitor; saturates at the limit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      if (!bus.mon_req || w_pick == OWN_MON)
        r_starve_cnt <= '0;
      else if (w_pick != OWN_NONE && r_starve_cnt < 3'(MON_WAIT_MAX))
        r_starve_cnt <= r_starve_cnt + 3'd1;
    end
  end
`else
  assign w_force_mon = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_NONE;
      r_we        <= 1'b0;
      r_ack       <= '0;
      r_rdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ack <= '0;
          if (w_pick != OWN_NONE) begin
            r_owner     <= w_pick;
            r_we        <= w_sel_we;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_mem_re    <= ~w_sel_we;
            r_mem_we    <= w_sel_we;
            r_state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r_mem_re <= 1'b0;
          r_mem_we <= 1'b0;
          r_state  <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (!r_we) r_rdata <= bus.mem_rdata;
          r_ack   <= {r_owner == OWN_MON, r_owner == OWN_LD, r_owner == OWN_CPU};
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          r_ack   <= '0;
          r_owner <= OWN_NONE;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cpu_ack   = r_ack[0];
  assign bus.ld_ack    = r_ack[1];
  assign bus.mon_ack   = r_ack[2];
  assign bus.rdata     = r_rdata;
  assign bus.owner     = r_owner;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_re    = r_mem_re;
  assign bus.mem_we    = r_mem_we;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with random traffic and a reference memory
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int MWM = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MON_WAIT_MAX(MWM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] phys_mem [256] = '{default: 8'h00};
  logic [7:0] ref_mem  [256] = '{default: 8'h00};

  always @(posedge clk) begin
    if (bus.mem_we) phys_mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= phys_mem[bus.mem_addr[7:0]];
  end

  typedef struct { logic [1:0] who; logic [7:0] rdata; int cyc; } ack_exp_t;
  typedef struct { logic we; logic [15:0] addr; logic [7:0] wdata; logic [1:0] who; int cyc; } stb_exp_t;

  ack_exp_t   ack_q[$];
  stb_exp_t   stb_q[$];
  logic [1:0] grant_log[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         strobe_cnt = 0;
  bit         sb_en = 1'b1;
  bit         owner_nz = 1'b0;
  logic [7:0] last_rd = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] ack_who();
    int n;
    n = int'(bus.cpu_ack) + int'(bus.ld_ack) + int'(bus.mon_ack);
    if (n != 1)      return 2'b00;
    if (bus.cpu_ack) return OWN_CPU;
    if (bus.ld_ack)  return OWN_LD;
    return OWN_MON;
  endfunction

  // Monitor: pops expectations whenever the DUT strobes memory or acks
  always @(negedge clk) begin
    stb_exp_t   s;
    ack_exp_t   a;
    logic       any_ack;
    any_ack = bus.cpu_ack | bus.ld_ack | bus.mon_ack;
    if (sb_en) begin
      if (bus.mem_re || bus.mem_we) begin
        if (stb_q.size() == 0) chk("unexpected_strobe", 1, 0);
        else begin
          s = stb_q.pop_front();
          chk("strobe_onehot", 32'(bus.mem_re & bus.mem_we), 0);
          chk("mem_we", 32'(bus.mem_we), 32'(s.we));
          chk("mem_addr", 32'(bus.mem_addr), 32'(s.addr));
          if (s.we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(s.wdata));
          chk("strobe_cycle", cyc, s.cyc);
          chk("owner_at_strobe", 32'(bus.owner), 32'(s.who));
        end
      end
      if (any_ack) begin
        if (ack_q.size() == 0) chk("unexpected_ack", 1, 0);
        else begin
          a = ack_q.pop_front();
          chk("ack_who", 32'(ack_who()), 32'(a.who));
          chk("rdata", 32'(bus.rdata), 32'(a.rdata));
          chk("ack_cycle", cyc, a.cyc);
          chk("owner_at_ack", 32'(bus.owner), 32'(a.who));
        end
      end
    end else begin
      if (any_ack) grant_log.push_back(ack_who());
      if (bus.mem_re || bus.mem_we) strobe_cnt++;
      if (bus.owner != 2'b00) owner_nz = 1'b1;
    end
  end

  task automatic drop_reqs();
    bus.cpu_req = 1'b0;
    bus.ld_req  = 1'b0;
    bus.mon_req = 1'b0;
  endtask

  task automatic do_txn(input logic [1:0] cs, input logic [1:0] who, input logic we,
                        input logic [15:0] addr, input logic [7:0] wd,
                        input logic [1:0] cs_mid, input bit noise);
    logic [7:0] exp_rd;
    bit         got;
    @(posedge clk); #1;
    bus.cpustate = cs;
    if (noise) begin
      case (cs)
        CS_IN:    begin bus.cpu_req = 1'b1; bus.mon_req = 1'b1; end
        CS_CHECK: begin bus.cpu_req = 1'b1; bus.ld_req  = 1'b1; end
        default:  bus.ld_req = 1'b1;
      endcase
      bus.cpu_addr = 16'(~addr); bus.ld_addr = 16'(~addr); bus.mon_addr = 16'(~addr);
    end
    case (who)
      OWN_CPU: begin bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd; bus.cpu_req = 1'b1; end
      OWN_LD:  begin bus.ld_we  = we; bus.ld_addr  = addr; bus.ld_wdata  = wd; bus.ld_req  = 1'b1; end
      default: begin bus.mon_we = we; bus.mon_addr = addr; bus.mon_wdata = wd; bus.mon_req = 1'b1; end
    endcase
    exp_rd = we ? last_rd : ref_mem[addr[7:0]];
    if (we) ref_mem[addr[7:0]] = wd;
    else    last_rd = exp_rd;
    stb_q.push_back('{we: we, addr: addr, wdata: wd, who: who, cyc: cyc + 1});
    ack_q.push_back('{who: who, rdata: exp_rd, cyc: cyc + 3});
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(posedge clk); #1;
      if (i == 0) bus.cpustate = cs_mid;
      case (who)
        OWN_CPU: got = bus.cpu_ack;
        OWN_LD:  got = bus.ld_ack;
        default: got = bus.mon_ack;
      endcase
    end
    if (!got) begin
      chk("ack_timeout", 0, 1);
      ack_q.delete();
      stb_q.delete();
    end
    @(posedge clk); #1;
    drop_reqs();
  endtask

  initial begin
    logic [1:0] cs, who, cs_mid, exp_g;
    bus.cpustate = CS_IDLE;
    bus.cpu_we = 0; bus.ld_we = 0; bus.mon_we = 0;
    bus.cpu_addr = 0; bus.ld_addr = 0; bus.mon_addr = 0;
    bus.cpu_wdata = 0; bus.ld_wdata = 0; bus.mon_wdata = 0;
    drop_reqs();

    repeat (3) @(posedge clk);
    #1;
    chk("reset_owner", 32'(bus.owner), 0);
    chk("reset_acks", 32'({bus.cpu_ack, bus.ld_ack, bus.mon_ack}), 0);
    chk("reset_mem_re", 32'(bus.mem_re), 0);
    chk("reset_mem_we", 32'(bus.mem_we), 0);
    chk("reset_mem_addr", 32'(bus.mem_addr), 0);
    chk("reset_mem_wdata", 32'(bus.mem_wdata), 0);
    chk("reset_rdata", 32'(bus.rdata), 0);
    rst = 1'b1;

    do_txn(CS_IN, OWN_LD, 1'b1, 16'h0010, 8'hA5, CS_IN, 1'b0);
    do_txn(CS_CHECK, OWN_MON, 1'b0, 16'h0010, 8'h00, CS_CHECK, 1'b0);
    do_txn(CS_RUN, OWN_CPU, 1'b0, 16'h0010, 8'h00, CS_CHECK, 1'b0);

    // Reset asserted during CAPTURE of a cpu read: transaction is dropped
    @(posedge clk); #1;
    bus.cpustate = CS_RUN; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010; bus.cpu_req = 1'b1;
    stb_q.push_back('{we: 1'b0, addr: 16'h0010, wdata: 8'h00, who: OWN_CPU, cyc: cyc + 1});
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_mid_owner", 32'(bus.owner), 0);
    chk("rst_mid_acks", 32'({bus.cpu_ack, bus.ld_ack, bus.mon_ack}), 0);
    chk("rst_mid_mem_re", 32'(bus.mem_re), 0);
    chk("rst_mid_mem_we", 32'(bus.mem_we), 0);
    chk("rst_mid_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_mid_rdata", 32'(bus.rdata), 0);
    drop_reqs();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    last_rd = 8'h00;
    do_txn(CS_IN, OWN_LD, 1'b1, 16'h0011, 8'h3C, CS_IN, 1'b0);
    do_txn(CS_RUN, OWN_CPU, 1'b0, 16'h0011, 8'h00, CS_RUN, 1'b0);

    // cpu and monitor held together in RUN
    sb_en = 1'b0;
    grant_log.delete();
    @(posedge clk); #1;
    bus.cpustate = CS_RUN;
    bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0020;
    bus.mon_we = 1'b0; bus.mon_addr = 16'h0020;
    bus.cpu_req = 1'b1; bus.mon_req = 1'b1;
    for (int i = 0; i < 60 && grant_log.size() < 6; i++) @(posedge clk);
    #1;
    drop_reqs();
    repeat (6) @(posedge clk);
    chk("starve_grants_seen", 32'(grant_log.size() >= 6), 1);
    for (int k = 0; k < 6 && k < grant_log.size(); k++) begin
`ifdef MEM_ARB_STARVE_EN
      exp_g = ((k % (MWM + 1)) == MWM) ? OWN_MON : OWN_CPU;
`else
      exp_g = OWN_CPU;
`endif
      chk($sformatf("starve_grant_%0d", k), 32'(grant_log[k]), 32'(exp_g));
    end
    last_rd = ref_mem[8'h20];

    // Ineligible requesters in IN state
    grant_log.delete();
    strobe_cnt = 0;
    owner_nz = 1'b0;
    @(posedge clk); #1;
    bus.cpustate = CS_IN;
    bus.cpu_req = 1'b1; bus.mon_req = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    drop_reqs();
    repeat (2) @(posedge clk);
    chk("inelig_acks", grant_log.size(), 0);
    chk("inelig_strobes", strobe_cnt, 0);
    chk("inelig_owner", 32'(owner_nz), 0);
    sb_en = 1'b1;

    for (int n = 0; n < 60; n++) begin
      cs = 2'($urandom_range(1, 3));
      case (cs)
        CS_IN:    who = OWN_LD;
        CS_CHECK: who = OWN_MON;
        default:  who = ($urandom_range(0, 1) == 0) ? OWN_CPU : OWN_MON;
      endcase
      cs_mid = 2'($urandom_range(0, 3));
      do_txn(cs, who, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)),
             8'($urandom_range(0, 255)), cs_mid, 1'($urandom_range(0, 1)));
    end

    repeat (4) @(posedge clk);
    chk("ack_queue_drained", ack_q.size(), 0);
    chk("strobe_queue_drained", stb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete (checks %0d)", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
